// File: rtl/ram_arb_pkg.sv
// rtl/ram_arb_pkg.sv - shared search-RAM widths and arbiter state type
package ram_arb_pkg;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} arb_state_t;

endpackage

// File: rtl/ram_arb_if.sv
// rtl/ram_arb_if.sv - requester ports and RAM pins of the search-RAM arbiter
interface ram_arb_if
  import ram_arb_pkg::*;
#(
  parameter int AW = ADDR_W,
  parameter int DW = DATA_W
) ();

  logic          req0, req1;
  logic          we0, we1;
  logic          lock0, lock1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1;
  logic          rvalid0, rvalid1;
  logic [DW-1:0] rdata;
  logic [AW-1:0] ram_addr;
  logic          ram_wren;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_q;

  // The arbiter side; requesters and the RAM instance sit on the master side.
  modport slave (
    input  req0, req1, we0, we1, lock0, lock1, addr0, addr1, wdata0, wdata1, ram_q,
    output gnt0, gnt1, rvalid0, rvalid1, rdata, ram_addr, ram_wren, ram_wdata
  );

  modport master (
    output req0, req1, we0, we1, lock0, lock1, addr0, addr1, wdata0, wdata1, ram_q,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata, ram_addr, ram_wren, ram_wdata
  );

endinterface

// File: rtl/ram_arbiter_rr_pick.sv
// rtl/ram_arbiter_rr_pick.sv - two-way round-robin chooser
module rr_pick (
  input  logic req0,
  input  logic req1,
  input  logic last_owner,
  output logic valid,
  output logic winner
);

  // On a tie the port that did not own the RAM last goes first.
  assign valid  = req0 | req1;
  assign winner = (req0 & req1) ? ~last_owner : req1;

endmodule

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - round-robin owner of the single-port search RAM with lock and hold limit
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input logic       clk,
  input logic       reset,
  ram_arb_if.slave  bus
);

  localparam int              HOLD_W   = $clog2(MAX_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);

  arb_state_t        state, state_next;
  logic              last_owner;
  logic [HOLD_W-1:0] hold_cnt, hold_inc;
  logic              rvalid0_q, rvalid1_q;
  logic              pick_valid, pick_winner;
  logic              own0, own1, gnt0, gnt1, granted;
  logic              req_cur, lock_cur, req_other;

  rr_pick u_pick (
    .req0       (bus.req0),
    .req1       (bus.req1),
    .last_owner (last_owner),
    .valid      (pick_valid),
    .winner     (pick_winner)
  );

  assign own0    = (state == OWN0);
  assign own1    = (state == OWN1);
  assign gnt0    = own0 & bus.req0 & ~reset;
  assign gnt1    = own1 & bus.req1 & ~reset;
  assign granted = gnt0 | gnt1;

  assign bus.gnt0      = gnt0;
  assign bus.gnt1      = gnt1;
  assign bus.ram_addr  = own1 ? bus.addr1 : bus.addr0;
  assign bus.ram_wdata = own1 ? bus.wdata1 : bus.wdata0;
  assign bus.ram_wren  = (gnt0 & bus.we0) | (gnt1 & bus.we1);
  assign bus.rdata     = bus.ram_q;
  assign bus.rvalid0   = rvalid0_q & ~reset;
  assign bus.rvalid1   = rvalid1_q & ~reset;

  // Saturates so a long locked run with no contender cannot wrap.
  assign hold_inc = (granted && hold_cnt != HOLD_MAX) ? hold_cnt + 1'b1 : hold_cnt;

  always_comb begin
    req_cur   = 1'b0;
    lock_cur  = 1'b0;
    req_other = 1'b0;
    if (own0) begin
      req_cur   = bus.req0;
      lock_cur  = bus.lock0;
      req_other = bus.req1;
    end else if (own1) begin
      req_cur   = bus.req1;
      lock_cur  = bus.lock1;
      req_other = bus.req0;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (pick_valid) state_next = pick_winner ? OWN1 : OWN0;
      end
      OWN0, OWN1: begin
        if (!lock_cur && (granted || !req_cur))
          state_next = IDLE;
        else if (lock_cur && req_other && hold_inc == HOLD_MAX)
          state_next = own0 ? OWN1 : OWN0;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_owner <= 1'b1;
      hold_cnt   <= '0;
      rvalid0_q  <= 1'b0;
      rvalid1_q  <= 1'b0;
    end else begin
      state     <= state_next;
      hold_cnt  <= (state_next != state) ? '0 : hold_inc;
      rvalid0_q <= gnt0 & ~bus.we0;
      rvalid1_q <= gnt1 & ~bus.we1;
      if (granted) last_owner <= gnt1;
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - randomized and directed bench for ram_arbiter against a behavioural model
module tb_ram_arbiter;
  import ram_arb_pkg::*;

  localparam int MAX_HOLD = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ram_arb_if bus ();

  ram_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // RAM instance driven only by the arbiter pins
  logic [7:0] ram [32] = '{default: 8'h00};
  always @(posedge clk) begin
    if (bus.ram_wren) ram[bus.ram_addr] <= bus.ram_wdata;
    bus.ram_q <= ram[bus.ram_addr];
  end

  int vectors = 0;
  int miscompares = 0;

  // reference model: owner -1 = nobody
  int         owner = -1;
  bit         last = 1'b1;
  int         cnt = 0;
  bit         pv0 = 1'b0, pv1 = 1'b0;
  logic [7:0] pd0 = '0, pd1 = '0;
  logic [7:0] shadow [32] = '{default: 8'h00};

  // values sampled during the latest step
  bit         s_g0, s_g1, s_wren, s_rv0, s_rv1;
  logic [4:0] s_addr;
  logic [7:0] s_rdata;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    bit e_g0, e_g1, e_wren, e_rv0, e_rv1, mine_req, mine_lock, other_req, mine_g;
    @(negedge clk);
    e_g0   = !reset && owner == 0 && bus.req0;
    e_g1   = !reset && owner == 1 && bus.req1;
    e_wren = (e_g0 && bus.we0) || (e_g1 && bus.we1);
    e_rv0  = !reset && pv0;
    e_rv1  = !reset && pv1;
    check("gnt0", bus.gnt0, e_g0);
    check("gnt1", bus.gnt1, e_g1);
    check("ram_wren", bus.ram_wren, e_wren);
    if (e_g0 || e_g1) check("ram_addr", bus.ram_addr, e_g1 ? bus.addr1 : bus.addr0);
    if (e_wren) check("ram_wdata", bus.ram_wdata, e_g1 ? bus.wdata1 : bus.wdata0);
    check("rvalid0", bus.rvalid0, e_rv0);
    check("rvalid1", bus.rvalid1, e_rv1);
    if (e_rv0) check("rdata0", bus.rdata, pd0);
    if (e_rv1) check("rdata1", bus.rdata, pd1);
    s_g0 = bus.gnt0; s_g1 = bus.gnt1; s_wren = bus.ram_wren; s_addr = bus.ram_addr;
    s_rv0 = bus.rvalid0; s_rv1 = bus.rvalid1; s_rdata = bus.rdata;
    @(posedge clk);
    if (reset) begin
      owner = -1; last = 1'b1; cnt = 0; pv0 = 1'b0; pv1 = 1'b0;
    end else begin
      pv0 = e_g0 && !bus.we0; pd0 = shadow[bus.addr0];
      pv1 = e_g1 && !bus.we1; pd1 = shadow[bus.addr1];
      if (e_g0 && bus.we0) shadow[bus.addr0] = bus.wdata0;
      if (e_g1 && bus.we1) shadow[bus.addr1] = bus.wdata1;
      if (owner < 0) begin
        if (bus.req0 && bus.req1) owner = last ? 0 : 1;
        else if (bus.req0)        owner = 0;
        else if (bus.req1)        owner = 1;
        cnt = 0;
      end else begin
        mine_req  = (owner == 0) ? bus.req0  : bus.req1;
        mine_lock = (owner == 0) ? bus.lock0 : bus.lock1;
        other_req = (owner == 0) ? bus.req1  : bus.req0;
        mine_g    = e_g0 || e_g1;
        if (mine_g) begin last = (owner == 1); cnt++; end
        if (!mine_lock && (mine_g || !mine_req)) begin
          owner = -1; cnt = 0;
        end else if (mine_lock && other_req && cnt >= MAX_HOLD) begin
          owner = 1 - owner; cnt = 0;
        end
      end
    end
    #1;
  endtask

  task automatic set_port(input int p, input bit r, input bit w, input logic [4:0] a,
                          input logic [7:0] d, input bit lk);
    if (p == 0) begin
      bus.req0 = r; bus.we0 = w; bus.addr0 = a; bus.wdata0 = d; bus.lock0 = lk;
    end else begin
      bus.req1 = r; bus.we1 = w; bus.addr1 = a; bus.wdata1 = d; bus.lock1 = lk;
    end
  endtask

  task automatic access(input int p, input bit w, input logic [4:0] a, input logic [7:0] d,
                        output bit wren_at_gnt);
    bit done = 1'b0;
    wren_at_gnt = 1'b0;
    set_port(p, 1'b1, w, a, d, 1'b0);
    for (int i = 0; i < 8 && !done; i++) begin
      step();
      done = (p == 0) ? s_g0 : s_g1;
      if (done) wren_at_gnt = s_wren;
    end
    check("access_granted", done, 1'b1);
    set_port(p, 1'b0, 1'b0, 5'd0, 8'd0, 1'b0);
  endtask

  task automatic tie(output int first, output int second);
    first = -1; second = -1;
    set_port(0, 1'b1, 1'b0, 5'd1, 8'd0, 1'b0);
    set_port(1, 1'b1, 1'b0, 5'd2, 8'd0, 1'b0);
    for (int i = 0; i < 12 && second < 0; i++) begin
      step();
      if (s_g0) begin
        if (first < 0) first = 0; else second = 0;
        bus.req0 = 1'b0;
      end
      if (s_g1) begin
        if (first < 0) first = 1; else second = 1;
        bus.req1 = 1'b0;
      end
    end
  endtask

  initial begin
    bit wr;
    int first, second, run, gap, n0, last0;
    bit seen1;

    reset = 1'b1;
    set_port(0, 1'b0, 1'b0, 5'd0, 8'd0, 1'b0);
    set_port(1, 1'b0, 1'b0, 5'd0, 8'd0, 1'b0);

    // reset with random requests
    for (int i = 0; i < 2; i++) begin
      set_port(0, 1'($urandom), 1'($urandom), 5'($urandom), 8'($urandom), 1'($urandom));
      set_port(1, 1'($urandom), 1'($urandom), 5'($urandom), 8'($urandom), 1'($urandom));
      step();
      check("rst_quiet", {s_g0, s_g1, s_wren, s_rv0, s_rv1}, 5'b0);
    end
    reset = 1'b0;
    set_port(0, 1'b0, 1'b0, 5'd0, 8'd0, 1'b0);
    set_port(1, 1'b0, 1'b0, 5'd0, 8'd0, 1'b0);
    step();

    // load RAM[5]=0x0A, then port 0 reads it from IDLE
    access(1, 1'b1, 5'd5, 8'h0A, wr);
    step();
    set_port(0, 1'b1, 1'b0, 5'd5, 8'd0, 1'b0);
    step();
    check("rd_no_gnt_cycle0", s_g0, 1'b0);
    step();
    check("rd_gnt_cycle1", s_g0, 1'b1);
    check("rd_addr", s_addr, 5'd5);
    set_port(0, 1'b0, 1'b0, 5'd0, 8'd0, 1'b0);
    step();
    check("rd_rvalid", s_rv0, 1'b1);
    check("rd_data", s_rdata, 8'h0A);

    // ties after reset
    reset = 1'b1; step(); reset = 1'b0;
    tie(first, second);
    check("tie_first", first, 0);
    check("tie_second", second, 1);
    tie(first, second);
    check("tie_again", first, 0);

    // port 1 writes 0xFF to 31, port 0 reads it back
    access(1, 1'b1, 5'd31, 8'hFF, wr);
    check("wr_wren_at_gnt", wr, 1'b1);
    step();
    check("wr_wren_after", s_wren, 1'b0);
    access(0, 1'b0, 5'd31, 8'd0, wr);
    check("rd31_wren", wr, 1'b0);
    step();
    check("rd31_rvalid", s_rv0, 1'b1);
    check("rd31_data", s_rdata, 8'hFF);

    // locked port 0 against a waiting port 1
    reset = 1'b1; step(); reset = 1'b0;
    set_port(0, 1'b1, 1'b0, 5'd0, 8'd0, 1'b1);
    set_port(1, 1'b1, 1'b0, 5'd3, 8'd0, 1'b0);
    run = 0; gap = -1; n0 = 0; last0 = -100; seen1 = 1'b0;
    for (int i = 0; i < 40 && n0 < 10; i++) begin
      step();
      if (s_g0) begin
        if (!seen1) run++;
        n0++; last0 = i;
        bus.addr0 = 5'(n0);
      end
      if (s_g1) begin
        if (!seen1) begin seen1 = 1'b1; gap = i - last0; end
        bus.req1 = 1'b0;
      end
    end
    set_port(0, 1'b0, 1'b0, 5'd0, 8'd0, 1'b0);
    check("hold_run", run, MAX_HOLD);
    check("handover_gap", gap, 1);
    check("regain_all", n0, 10);
    step();

    // reset in the grant cycle of a port 0 read
    set_port(0, 1'b1, 1'b0, 5'd7, 8'd0, 1'b0);
    step();
    reset = 1'b1;
    step();
    check("rst_gnt_masked", s_g0, 1'b0);
    reset = 1'b0;
    step();
    check("rst_no_rvalid", s_rv0, 1'b0);
    check("rst_idle_no_gnt", s_g0, 1'b0);
    step();
    check("rst_then_gnt", s_g0, 1'b1);
    set_port(0, 1'b0, 1'b0, 5'd0, 8'd0, 1'b0);
    step();

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      for (int p = 0; p < 2; p++) begin
        bit r = (p == 0) ? bus.req0 : bus.req1;
        bit g = (p == 0) ? s_g0 : s_g1;
        if (!r || g)
          set_port(p, ($urandom_range(2) != 0), 1'($urandom), 5'($urandom), 8'($urandom),
                   ($urandom_range(3) == 0));
        else if ($urandom_range(15) == 0)
          set_port(p, 1'b0, 1'b0, 5'd0, 8'd0, 1'b0);
        else if ($urandom_range(7) == 0) begin
          if (p == 0) bus.lock0 = ~bus.lock0; else bus.lock1 = ~bus.lock1;
        end
      end
      reset = ($urandom_range(199) == 0);
      step();
    end
    reset = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
